// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmit and receive sides.
// Holds the frame geometry, the WS polarity and the parameter legality checks.
package i2s_pkg;

  typedef enum logic {
    WS_LEFT  = 1'b0,
    WS_RIGHT = 1'b1
  } ws_e;

  function automatic int frame_len(input int slot_bits);
    return 2 * slot_bits;
  endfunction

  function automatic bit div_legal(input int div);
    return (div >= 2) && ((div & (div - 1)) == 0);
  endfunction

  function automatic bit slot_legal(input int slot_bits, input int data_bits);
    return slot_bits >= data_bits;
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Parallel sample bus between the audio path and the I2S transmitter.
interface i2s_tx_if #(
  parameter int I2S_DATA_BITS = 16
);
  logic signed [I2S_DATA_BITS-1:0] apdata_left;
  logic signed [I2S_DATA_BITS-1:0] apdata_right;
  logic                            apdata_valid;
  logic                            sample_req;
  logic                            underrun;
  logic                            overrun;

  modport master (
    output apdata_left, apdata_right, apdata_valid,
    input  sample_req, underrun, overrun
  );

  modport slave (
    input  apdata_left, apdata_right, apdata_valid,
    output sample_req, underrun, overrun
  );
endinterface

// File: rtl/i2s_tx_clkgen.sv
// Bit clock and frame timing for the I2S transmitter.
// fall/load flag the AMCLK cycle whose edge drops BCK / loads a new frame.
module i2s_tx_clkgen
  import i2s_pkg::*;
#(
  parameter int MCLK_DIVIDER = 4,
  parameter int SLOT_BITS    = 32
) (
  input  logic AMCLK_i,
  input  logic reset_n,
  output logic bck,
  output logic fall,
  output logic load,
  output logic ws_next
);

  localparam int FRAME_BITS = frame_len(SLOT_BITS);
  localparam int CW         = $clog2(MCLK_DIVIDER);
  localparam int BW         = $clog2(FRAME_BITS);

  logic [CW-1:0] bck_ctr;
  logic [BW-1:0] bit_ctr;
  logic [BW-1:0] bit_next;

  // WS is derived from the value bit_ctr takes on this fall
  always_comb begin
    fall     = (bck_ctr == CW'(MCLK_DIVIDER - 1));
    bit_next = (bit_ctr == BW'(FRAME_BITS - 1)) ? '0 : bit_ctr + BW'(1);
    load     = fall && (bit_ctr == '0);
    ws_next  = (bit_next >= BW'(SLOT_BITS)) ? WS_RIGHT : WS_LEFT;
  end

  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      bck_ctr <= '0;
      bit_ctr <= '0;
      bck     <= 1'b0;
    end else begin
      bck_ctr <= fall ? '0 : bck_ctr + CW'(1);
      if (fall) begin
        bit_ctr <= bit_next;
      end
      if (fall) begin
        bck <= 1'b0;
      end else if (bck_ctr == CW'(MCLK_DIVIDER / 2 - 1)) begin
        bck <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-deep pending buffer, frame shifter and status pulses.
// BCK and WS are generated locally from AMCLK_i.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int I2S_DATA_BITS = 16,
  parameter int MCLK_DIVIDER  = 4,
  parameter int SLOT_BITS     = 32
) (
  input  logic     AMCLK_i,
  input  logic     reset_n,
  i2s_tx_if.slave  ap,
  output logic     I2S_BCK_o,
  output logic     I2S_WS_o,
  output logic     I2S_DATA_o
);

  localparam int FRAME_BITS = frame_len(SLOT_BITS);

  if (!div_legal(MCLK_DIVIDER)) begin : g_bad_divider
    $error("i2s_tx: MCLK_DIVIDER must be a power of 2 and at least 2");
  end
  if (!slot_legal(SLOT_BITS, I2S_DATA_BITS)) begin : g_bad_slot
    $error("i2s_tx: SLOT_BITS must be at least I2S_DATA_BITS");
  end

  logic                            fall;
  logic                            load;
  logic                            ws_next;
  logic                            pend_full;
  logic signed [I2S_DATA_BITS-1:0] pend_l, pend_r;
  logic signed [I2S_DATA_BITS-1:0] last_l, last_r;
  logic signed [I2S_DATA_BITS-1:0] src_l, src_r;
  logic [FRAME_BITS-1:0]           frame;
  logic [FRAME_BITS-1:0]           frame_next;

  i2s_tx_clkgen #(
    .MCLK_DIVIDER(MCLK_DIVIDER),
    .SLOT_BITS   (SLOT_BITS)
  ) u_clkgen (
    .AMCLK_i(AMCLK_i),
    .reset_n(reset_n),
    .bck    (I2S_BCK_o),
    .fall   (fall),
    .load   (load),
    .ws_next(ws_next)
  );

  // Pending entry wins; otherwise a same-cycle strobe bypasses; otherwise hold
  always_comb begin
    src_l = last_l;
    src_r = last_r;
    if (pend_full) begin
      src_l = pend_l;
      src_r = pend_r;
    end else if (ap.apdata_valid) begin
      src_l = ap.apdata_left;
      src_r = ap.apdata_right;
    end
    frame_next = '0;
    frame_next[FRAME_BITS-1 -: I2S_DATA_BITS] = src_l;
    frame_next[SLOT_BITS-1  -: I2S_DATA_BITS] = src_r;
  end

  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      pend_full     <= 1'b0;
      pend_l        <= '0;
      pend_r        <= '0;
      last_l        <= '0;
      last_r        <= '0;
      frame         <= '0;
      I2S_WS_o      <= WS_LEFT;
      I2S_DATA_o    <= 1'b0;
      ap.sample_req <= 1'b0;
      ap.underrun   <= 1'b0;
      ap.overrun    <= 1'b0;
    end else begin
      ap.sample_req <= load;
      ap.underrun   <= load && !pend_full && !ap.apdata_valid;
      ap.overrun    <= ap.apdata_valid && pend_full && !load;

      if (ap.apdata_valid && !(load && !pend_full)) begin
        pend_l    <= ap.apdata_left;
        pend_r    <= ap.apdata_right;
        pend_full <= 1'b1;
      end else if (load) begin
        pend_full <= 1'b0;
      end

      if (load) begin
        last_l <= src_l;
        last_r <= src_r;
      end

      // The load fall already presents the new left MSB
      if (fall) begin
        I2S_WS_o <= ws_next;
        if (load) begin
          frame      <= frame_next;
          I2S_DATA_o <= frame_next[FRAME_BITS-1];
        end else begin
          frame      <= frame << 1;
          I2S_DATA_o <= frame[FRAME_BITS-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed self-checking bench for i2s_tx: 16-bit and 32-bit slot instances
// share clock, reset and sample stimulus.
module tb_i2s_tx;

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [15:0] in_l, in_r;
  logic               in_valid;
  int                 checks = 0;
  int                 failures = 0;
  int                 cyc = 0;

  logic bck16, ws16, data16;
  logic bck32, ws32, data32;

  i2s_tx_if #(.I2S_DATA_BITS(16)) if16 ();
  i2s_tx_if #(.I2S_DATA_BITS(16)) if32 ();

  assign if16.apdata_left  = in_l;
  assign if16.apdata_right = in_r;
  assign if16.apdata_valid = in_valid;
  assign if32.apdata_left  = in_l;
  assign if32.apdata_right = in_r;
  assign if32.apdata_valid = in_valid;

  i2s_tx #(.I2S_DATA_BITS(16), .MCLK_DIVIDER(4), .SLOT_BITS(16)) dut (
    .AMCLK_i   (clk),
    .reset_n   (reset_n),
    .ap        (if16.slave),
    .I2S_BCK_o (bck16),
    .I2S_WS_o  (ws16),
    .I2S_DATA_o(data16)
  );

  i2s_tx #(.I2S_DATA_BITS(16), .MCLK_DIVIDER(4), .SLOT_BITS(32)) dut32 (
    .AMCLK_i   (clk),
    .reset_n   (reset_n),
    .ap        (if32.slave),
    .I2S_BCK_o (bck32),
    .I2S_WS_o  (ws32),
    .I2S_DATA_o(data32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    in_l     = l;
    in_r     = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called in a load cycle; gathers the 32 bits presented on successive falls
  task automatic capture16(output logic [31:0] w);
    w = '0;
    for (int k = 0; k < 32; k++) begin
      w[31-k] = data16;
      if (k < 31) repeat (4) tick();
    end
  endtask

  logic [63:0] d16, w16, d32, w32;
  logic [31:0] fw;
  int          sr_at[3];
  int          un_at[2];
  int          sr_n, un_n, ov_n;

  initial begin
    reset_n  = 1'b0;
    in_l     = '0;
    in_r     = '0;
    in_valid = 1'b0;
    d16 = '0; w16 = '0; d32 = '0; w32 = '0;
    sr_n = 0; un_n = 0; ov_n = 0;
    sr_at = '{0, 0, 0};
    un_at = '{0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs16", {bck16, ws16, data16, if16.sample_req, if16.underrun, if16.overrun}, 64'h0);
    check("reset_outputs32", {bck32, ws32, data32, if32.sample_req, if32.underrun, if32.overrun}, 64'h0);

    in_l     = 16'hA5C3;
    in_r     = 16'h0F01;
    in_valid = 1'b1;
    reset_n  = 1'b1;
    cyc      = 0;

    for (int c = 1; c <= 264; c++) begin
      tick();
      if (cyc == 1) begin
        in_valid = 1'b0;
        check("bck_low_c1", bck16, 1'b0);
      end
      if (cyc == 2) check("first_bck_rise", bck16, 1'b1);
      if (cyc == 4) check("first_load_c4", {bck16, ws16, data16, if16.sample_req}, 4'b0011);
      if (cyc >= 4 && (cyc % 4) == 0 && cyc <= 256) begin
        d16[63-(cyc-4)/4] = data16;
        w16[63-(cyc-4)/4] = ws16;
        d32[63-(cyc-4)/4] = data32;
        w32[63-(cyc-4)/4] = ws32;
      end
      if (if16.sample_req) begin
        if (sr_n < 3) sr_at[sr_n] = cyc;
        sr_n++;
      end
      if (if16.underrun) begin
        if (un_n < 2) un_at[un_n] = cyc;
        un_n++;
      end
      if (if16.overrun) ov_n++;
    end

    check("data16_two_frames", d16, 64'hA5C30F01_A5C30F01);
    check("ws16_two_frames",   w16, 64'h0001FFFE_0001FFFE);
    check("data32_padded",     d32, 64'hA5C30000_0F010000);
    check("ws32_frame",        w32, 64'h00000001_FFFFFFFE);
    check("sample_req_count",  sr_n, 3);
    check("sample_req_at0",    sr_at[0], 4);
    check("sample_req_at1",    sr_at[1], 132);
    check("sample_req_at2",    sr_at[2], 260);
    check("underrun_count",    un_n, 2);
    check("underrun_at0",      un_at[0], 132);
    check("overrun_none",      ov_n, 0);

    wait_until(299);
    strobe(16'h1234, 16'h5678);
    check("first_strobe_no_ovr", if16.overrun, 1'b0);
    wait_until(309);
    strobe(16'h8001, 16'h7FFE);
    check("second_strobe_ovr", if16.overrun, 1'b1);
    tick();
    check("ovr_one_cycle", if16.overrun, 1'b0);
    wait_until(388);
    check("ovr_frame_load", {if16.sample_req, if16.underrun}, 2'b10);
    capture16(fw);
    check("ovr_frame_data", fw, 32'h8001_7FFE);

    wait_until(516);
    check("hold_underrun", {if16.sample_req, if16.underrun}, 2'b11);
    capture16(fw);
    check("hold_frame_data", fw, 32'h8001_7FFE);

    wait_until(643);
    strobe(16'h6C39, 16'hF00D);
    check("bypass_load", {if16.sample_req, if16.underrun, if16.overrun}, 3'b100);
    capture16(fw);
    check("bypass_frame_data", fw, 32'h6C39_F00D);
    wait_until(772);
    check("bypass_left_no_pending", if16.underrun, 1'b1);

    wait_until(799);
    strobe(16'h0F0F, 16'hF0F0);
    check("w1_no_ovr", if16.overrun, 1'b0);
    wait_until(899);
    strobe(16'h3C3C, 16'hC3C3);
    check("full_plus_valid_load", {if16.sample_req, if16.underrun, if16.overrun}, 3'b100);
    capture16(fw);
    check("full_plus_valid_data", fw, 32'h0F0F_F0F0);
    wait_until(1028);
    check("queued_load", {if16.sample_req, if16.underrun}, 2'b10);
    capture16(fw);
    check("queued_data", fw, 32'h3C3C_C3C3);

    wait_until(1233);
    check("ws_right_bit20", ws16, 1'b1);
    wait_until(1234);
    check("bck_high_pre_reset", bck16, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async_reset", {bck16, ws16, data16, if16.sample_req, if16.underrun, if16.overrun}, 64'h0);
    tick();
    check("reset_held", {bck16, ws16, data16, if16.sample_req, if16.underrun, if16.overrun}, 64'h0);
    reset_n = 1'b1;
    cyc     = 0;
    tick();
    check("restart_bck_low", bck16, 1'b0);
    tick();
    check("restart_bck_rise", bck16, 1'b1);
    tick();
    tick();
    check("restart_load", {if16.sample_req, if16.underrun, if16.overrun, ws16, data16}, 5'b11000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
